// File: rtl/open_list_pkg.sv
// Shared constants and encodings for the A* open-list controller.
package open_list_pkg;
  localparam int unsigned OL_DEPTH = 400;
  localparam int unsigned OL_CW    = 8;
  localparam int unsigned OL_FW    = 12;
  localparam int unsigned OL_IW    = 9;

  typedef enum logic [1:0] {
    OP_SEARCH  = 2'b00,
    OP_INSERT  = 2'b01,
    OP_POP_MIN = 2'b10,
    OP_UPDATE  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    MIN_SCAN,
    WRITE,
    MOVE,
    RESP
  } state_t;
endpackage

// File: rtl/open_list_if.sv
// Command/response handshake between the A* search FSM and the open-list controller.
interface open_list_if
  import open_list_pkg::*;
#(
  parameter int unsigned CW = OL_CW,
  parameter int unsigned FW = OL_FW,
  parameter int unsigned IW = OL_IW
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_x;
  logic [CW-1:0] cmd_y;
  logic [FW-1:0] cmd_f;
  logic          rsp_valid;
  logic          rsp_found;
  logic          rsp_updated;
  logic          rsp_err;
  logic [IW-1:0] rsp_index;
  logic [CW-1:0] rsp_x;
  logic [CW-1:0] rsp_y;
  logic [FW-1:0] rsp_f;
  logic [IW-1:0] count;
  logic          empty;
  logic          full;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_f,
    input  cmd_ready, rsp_valid, rsp_found, rsp_updated, rsp_err,
           rsp_index, rsp_x, rsp_y, rsp_f, count, empty, full
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_f,
    output cmd_ready, rsp_valid, rsp_found, rsp_updated, rsp_err,
           rsp_index, rsp_x, rsp_y, rsp_f, count, empty, full
  );
endinterface

// File: rtl/open_list_ram.sv
// Open-list entry storage: one write port, combinational read by index, no reset.
module open_list_ram
  import open_list_pkg::*;
#(
  parameter int unsigned DEPTH = OL_DEPTH,
  parameter int unsigned IW    = OL_IW,
  parameter int unsigned W     = 2 * OL_CW + OL_FW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Scans probe one index past the last entry; keep that read in range.
  assign rdata_o = (raddr_i < IW'(DEPTH)) ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/open_list_ctrl.sv
// A* open-list controller: serialises SEARCH/INSERT/POP_MIN/UPDATE with linear scans.
module open_list_ctrl
  import open_list_pkg::*;
#(
  parameter int unsigned DEPTH = OL_DEPTH,
  parameter int unsigned CW    = OL_CW,
  parameter int unsigned FW    = OL_FW,
  parameter int unsigned IW    = OL_IW
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  open_list_if.slave  bus
);
  localparam int unsigned W = 2 * CW + FW;

  state_t        state_q;
  op_t           op_q;
  logic [CW-1:0] x_q, y_q, ent_x_q, ent_y_q;
  logic [FW-1:0] f_q, ent_f_q;
  logic [IW-1:0] idx_q, count_q, ent_idx_q;
  logic          found_q;

  logic          rsp_valid_q, rsp_found_q, rsp_updated_q, rsp_err_q;
  logic [IW-1:0] rsp_index_q;
  logic [CW-1:0] rsp_x_q, rsp_y_q;
  logic [FW-1:0] rsp_f_q;

  logic          we, accept, full_w;
  logic [IW-1:0] waddr, raddr;
  logic [W-1:0]  wdata, rdata;
  logic [CW-1:0] rd_x, rd_y;
  logic [FW-1:0] rd_f;

  assign full_w = (count_q == IW'(DEPTH));
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign {rd_x, rd_y, rd_f} = rdata;

  always_comb begin
    we    = ((state_q == WRITE) && (found_q || !full_w)) || (state_q == MOVE);
    waddr = ((state_q == MOVE) || found_q) ? ent_idx_q : count_q;
    wdata = (state_q == MOVE) ? rdata : {x_q, y_q, f_q};
    raddr = (state_q == MOVE) ? (count_q - IW'(1)) : idx_q;
  end

  open_list_ram #(.DEPTH(DEPTH), .IW(IW), .W(W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      op_q          <= OP_SEARCH;
      x_q           <= '0;
      y_q           <= '0;
      f_q           <= '0;
      ent_x_q       <= '0;
      ent_y_q       <= '0;
      ent_f_q       <= '0;
      ent_idx_q     <= '0;
      idx_q         <= '0;
      count_q       <= '0;
      found_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_found_q   <= 1'b0;
      rsp_updated_q <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_index_q   <= '0;
      rsp_x_q       <= '0;
      rsp_y_q       <= '0;
      rsp_f_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= op_t'(bus.cmd_op);
            x_q     <= bus.cmd_x;
            y_q     <= bus.cmd_y;
            f_q     <= bus.cmd_f;
            idx_q   <= '0;
            found_q <= 1'b0;
            case (op_t'(bus.cmd_op))
              OP_SEARCH, OP_UPDATE: state_q <= SCAN;
              OP_INSERT:            state_q <= WRITE;
              OP_POP_MIN:           state_q <= MIN_SCAN;
            endcase
          end
        end
        SCAN: begin
          if (idx_q == count_q) begin
            if (op_q == OP_UPDATE) begin
              state_q <= WRITE;
            end else begin
              rsp_valid_q <= 1'b1; rsp_found_q <= 1'b0; rsp_updated_q <= 1'b0; rsp_err_q <= 1'b0;
              rsp_index_q <= '0;   rsp_x_q <= '0;       rsp_y_q <= '0;         rsp_f_q <= '0;
              state_q     <= IDLE;
            end
          end else if (rd_x == x_q && rd_y == y_q) begin
            ent_x_q   <= rd_x;
            ent_y_q   <= rd_y;
            ent_f_q   <= rd_f;
            ent_idx_q <= idx_q;
            found_q   <= 1'b1;
            state_q   <= RESP;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        // Hit stage: decides between a plain found response and an f overwrite.
        RESP: begin
          if (op_q == OP_UPDATE && f_q < ent_f_q) begin
            state_q <= WRITE;
          end else begin
            rsp_valid_q <= 1'b1;      rsp_found_q <= 1'b1; rsp_updated_q <= 1'b0; rsp_err_q <= 1'b0;
            rsp_index_q <= ent_idx_q; rsp_x_q <= ent_x_q;  rsp_y_q <= ent_y_q;    rsp_f_q <= ent_f_q;
            state_q     <= IDLE;
          end
        end
        WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= IDLE;
          if (found_q) begin
            rsp_found_q <= 1'b1;      rsp_updated_q <= 1'b1; rsp_err_q <= 1'b0;
            rsp_index_q <= ent_idx_q; rsp_x_q <= ent_x_q;    rsp_y_q <= ent_y_q; rsp_f_q <= ent_f_q;
          end else if (full_w) begin
            rsp_found_q <= 1'b0; rsp_updated_q <= 1'b0; rsp_err_q <= 1'b1;
            rsp_index_q <= '0;   rsp_x_q <= x_q;        rsp_y_q <= y_q;    rsp_f_q <= f_q;
          end else begin
            rsp_found_q <= 1'b0;    rsp_updated_q <= (op_q == OP_UPDATE); rsp_err_q <= 1'b0;
            rsp_index_q <= count_q; rsp_x_q <= x_q; rsp_y_q <= y_q; rsp_f_q <= f_q;
            count_q     <= count_q + IW'(1);
          end
        end
        MIN_SCAN: begin
          if (idx_q == count_q) begin
            if (count_q == '0) begin
              rsp_valid_q <= 1'b1; rsp_found_q <= 1'b0; rsp_updated_q <= 1'b0; rsp_err_q <= 1'b1;
              rsp_index_q <= '0;   rsp_x_q <= '0;       rsp_y_q <= '0;         rsp_f_q <= '0;
              state_q     <= IDLE;
            end else begin
              state_q <= MOVE;
            end
          end else begin
            if (idx_q == '0 || rd_f < ent_f_q) begin
              ent_x_q   <= rd_x;
              ent_y_q   <= rd_y;
              ent_f_q   <= rd_f;
              ent_idx_q <= idx_q;
            end
            idx_q <= idx_q + IW'(1);
          end
        end
        MOVE: begin
          rsp_valid_q <= 1'b1;      rsp_found_q <= 1'b1; rsp_updated_q <= 1'b0; rsp_err_q <= 1'b0;
          rsp_index_q <= ent_idx_q; rsp_x_q <= ent_x_q;  rsp_y_q <= ent_y_q;    rsp_f_q <= ent_f_q;
          count_q     <= count_q - IW'(1);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE) && !rsp_valid_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_found   = rsp_found_q;
  assign bus.rsp_updated = rsp_updated_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_index   = rsp_index_q;
  assign bus.rsp_x       = rsp_x_q;
  assign bus.rsp_y       = rsp_y_q;
  assign bus.rsp_f       = rsp_f_q;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);
  assign bus.full        = full_w;
endmodule

// File: tb/tb_open_list_ctrl.sv
// Directed plus randomized check of open_list_ctrl against a list-level reference model.
module tb_open_list_ctrl;
  import open_list_pkg::*;

  localparam int DEPTH = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  open_list_if #(.CW(8), .FW(12), .IW(9)) bus ();
  open_list_ctrl #(.DEPTH(400), .CW(8), .FW(12), .IW(9)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int mx[DEPTH];
  int my[DEPTH];
  int mf[DEPTH];
  int n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int find(input int x, input int y);
    for (int i = 0; i < n; i++) if (mx[i] == x && my[i] == y) return i;
    return -1;
  endfunction

  // Issue one command; lat = posedges from accept edge to the response strobe (-1 on timeout).
  task automatic do_cmd(input int op, input int x, input int y, input int f, output int lat);
    int g = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_x     = 8'(x);
    bus.cmd_y     = 8'(y);
    bus.cmd_f     = 12'(f);
    while (!bus.cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.cmd_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid) break;
      if (lat > 2000) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic run_op(input int op, input int x, input int y, input int f);
    int i, m, lat;
    int e_lat = -1, e_found = -1, e_upd = 0, e_err = 0, e_idx = -1;
    int e_x = -1, e_y = -1, e_f = -1;
    i = find(x, y);
    case (op)
      OP_SEARCH: begin
        if (i >= 0) begin
          e_lat = i + 2; e_found = 1; e_idx = i; e_x = mx[i]; e_y = my[i]; e_f = mf[i];
        end else begin
          e_lat = n + 1; e_found = 0; e_idx = 0;
        end
      end
      OP_INSERT: begin
        e_lat = 1;
        if (n < DEPTH) begin
          e_idx = n; mx[n] = x; my[n] = y; mf[n] = f; n++;
        end else e_err = 1;
      end
      OP_POP_MIN: begin
        if (n == 0) begin
          e_lat = 1; e_err = 1; e_found = 0;
        end else begin
          m = 0;
          for (int k = 1; k < n; k++) if (mf[k] < mf[m]) m = k;
          e_lat = n + 2; e_found = 1; e_idx = m; e_x = mx[m]; e_y = my[m]; e_f = mf[m];
          mx[m] = mx[n-1]; my[m] = my[n-1]; mf[m] = mf[n-1];
          n--;
        end
      end
      default: begin
        if (i >= 0) begin
          e_found = 1; e_idx = i; e_x = mx[i]; e_y = my[i]; e_f = mf[i];
          if (f < mf[i]) begin
            e_lat = i + 3; e_upd = 1; mf[i] = f;
          end else e_lat = i + 2;
        end else if (n < DEPTH) begin
          e_lat = n + 2; e_found = 0; e_upd = 1; e_idx = n;
          mx[n] = x; my[n] = y; mf[n] = f; n++;
        end else begin
          e_found = 0; e_err = 1;
        end
      end
    endcase
    do_cmd(op, x, y, f, lat);
    if (e_lat >= 0)   chk("latency", lat, e_lat);
    if (e_found >= 0) chk("rsp_found", bus.rsp_found, e_found);
    chk("rsp_updated", bus.rsp_updated, e_upd);
    chk("rsp_err", bus.rsp_err, e_err);
    if (e_idx >= 0) chk("rsp_index", bus.rsp_index, e_idx);
    if (e_x >= 0) begin
      chk("rsp_x", bus.rsp_x, e_x);
      chk("rsp_y", bus.rsp_y, e_y);
      chk("rsp_f", bus.rsp_f, e_f);
    end
    chk("count", bus.count, n);
    chk("empty", bus.empty, n == 0);
    chk("full", bus.full, n == DEPTH);
    @(posedge clk);
    #1 chk("rsp_strobe_one_cycle", bus.rsp_valid, 0);
  endtask

  initial begin
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_f     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", bus.count, 0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_full", bus.full, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_found", bus.rsp_found, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_index", bus.rsp_index, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_reset", bus.cmd_ready, 1);

    run_op(OP_INSERT, 3, 4, 20);
    run_op(OP_INSERT, 5, 6, 10);
    run_op(OP_INSERT, 7, 8, 30);
    chk("tp_insert_index", bus.rsp_index, 2);
    chk("tp_count3", bus.count, 3);
    run_op(OP_SEARCH, 7, 8, 0);
    chk("tp_search_f_held", bus.rsp_f, 30);
    run_op(OP_SEARCH, 9, 9, 0);
    run_op(OP_UPDATE, 7, 8, 5);
    chk("tp_update_old_f", bus.rsp_f, 30);
    run_op(OP_UPDATE, 7, 8, 9);
    chk("tp_update_noop", bus.rsp_updated, 0);
    run_op(OP_UPDATE, 1, 1, 40);
    chk("tp_append_index", bus.rsp_index, 3);
    run_op(OP_POP_MIN, 0, 0, 0);
    chk("tp_pop_x", bus.rsp_x, 7);
    chk("tp_pop_f", bus.rsp_f, 5);
    chk("tp_pop_index", bus.rsp_index, 2);
    run_op(OP_SEARCH, 1, 1, 0);
    chk("tp_moved_index", bus.rsp_index, 2);

    run_op(OP_INSERT, 2, 2, 10);
    run_op(OP_POP_MIN, 0, 0, 0);
    chk("tp_tie_lowest_index", bus.rsp_index, 1);
    chk("tp_tie_x", bus.rsp_x, 5);

    while (n < DEPTH) run_op(OP_INSERT, $urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 4095));
    run_op(OP_INSERT, 9, 9, 1);
    chk("tp_full_err", bus.rsp_err, 1);
    chk("tp_full_count", bus.count, 400);
    run_op(OP_UPDATE, 250, 250, 1);
    run_op(OP_SEARCH, mx[DEPTH-1], my[DEPTH-1], 0);
    repeat (3) run_op(OP_POP_MIN, 0, 0, 0);
    while (n < DEPTH) run_op(OP_INSERT, $urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 4095));

    chk("midscan_ready", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SEARCH;
    bus.cmd_x     = 8'd250;
    bus.cmd_y     = 8'd250;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1 if (bus.rsp_valid) seen = 1;
    end
    chk("midscan_no_rsp_before_reset", seen, 0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midscan_async_count", bus.count, 0);
    chk("midscan_rsp_valid", bus.rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (bus.rsp_valid) seen = 1;
    end
    chk("midscan_dropped", seen, 0);
    chk("midscan_ready_after", bus.cmd_ready, 1);
    run_op(OP_SEARCH, 250, 250, 0);
    run_op(OP_POP_MIN, 0, 0, 0);
    chk("tp_empty_pop_err", bus.rsp_err, 1);

    repeat (300) begin
      int r;
      r = $urandom_range(0, 9);
      run_op(r < 3 ? OP_INSERT : r < 5 ? OP_UPDATE : r < 7 ? OP_POP_MIN : OP_SEARCH,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
    end
    while (n > 0) run_op(OP_POP_MIN, 0, 0, 0);
    run_op(OP_POP_MIN, 0, 0, 0);
    chk("drain_pop_err", bus.rsp_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
